yd_regfile_sb: RTL and testbench

Parametrised two-write, two-read register file for the Yduck core with an integrated pending-write scoreboard. It keeps the existing architectural map: a hard-wired zero register at address 0, DK at address 1, and the PC at the top address, with general registers in between. Per-register pending bits let the issue stage detect reads of registers whose multi-cycle producer (e.g. a memory load) has not yet written back. It sits between decode and execute, in place of the fixed 16-bit register file.

---
 rtl/yd_pkg.sv | 22 ++
 rtl/yd_regfile_sb_if.sv | 38 +++
 rtl/yd_scoreboard.sv | 47 ++++
 rtl/yd_regfile_sb.sv | 108 ++++++++++
 tb/tb_yd_regfile_sb.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/yd_pkg.sv
// Yduck register-file address map and sizing helpers, shared by the register file,
// its bus interface and the scoreboard.
package yd_pkg;

    localparam int unsigned ZEA = 0;
    localparam int unsigned DKA = 1;
    localparam int unsigned R0A = 2;

    // PC always lives at the top address of the map.
    function automatic int unsigned pca(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic int unsigned n_addr(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned num_gr(input int unsigned aw);
        return (32'd1 << aw) - 32'd3;
    endfunction

endpackage

// File: rtl/yd_regfile_sb_if.sv
// Decode/execute-side bus of the Yduck register file: write ports, read ports,
// PC control and scoreboard set port.
interface yd_regfile_sb_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          jpc;
    logic          hold;
    logic [DW-1:0] din0;
    logic [AW-1:0] waddr0;
    logic          we0;
    logic [DW-1:0] din1;
    logic [AW-1:0] waddr1;
    logic          we1;
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic          busy0;
    logic          busy1;
    logic          pset;
    logic [AW-1:0] psetaddr;
    logic [DW-1:0] pc;
    logic [DW-1:0] dkd;
    logic          pend_any;

    modport master (
        output jpc, hold, din0, waddr0, we0, din1, waddr1, we1,
               raddr0, raddr1, pset, psetaddr,
        input  dout0, dout1, busy0, busy1, pc, dkd, pend_any
    );

    modport slave (
        input  jpc, hold, din0, waddr0, we0, din1, waddr1, we1,
               raddr0, raddr1, pset, psetaddr,
        output dout0, dout1, busy0, busy1, pc, dkd, pend_any
    );
endinterface

// File: rtl/yd_scoreboard.sv
// Pending-write scoreboard: one bit per address, set by the issue stage, cleared by
// write-back. ZE and PC can never become pending.
module yd_scoreboard
    import yd_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [AW-1:0] set_addr,
    input  logic          clr0,
    input  logic [AW-1:0] clr0_addr,
    input  logic          clr1,
    input  logic [AW-1:0] clr1_addr,
    input  logic [AW-1:0] look0_addr,
    input  logic [AW-1:0] look1_addr,
    output logic          busy0,
    output logic          busy1,
    output logic          pend_any
);

    localparam int N = int'(n_addr(AW));
    localparam logic [AW-1:0] ZE_A = AW'(ZEA);
    localparam logic [AW-1:0] PC_A = AW'(pca(AW));

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;

    // The set is applied last so a new producer outranks a retiring one.
    always_comb begin
        pend_d = pend_q;
        if (clr0) pend_d[clr0_addr] = 1'b0;
        if (clr1) pend_d[clr1_addr] = 1'b0;
        if (set && set_addr != ZE_A && set_addr != PC_A) pend_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign busy0    = pend_q[look0_addr];
    assign busy1    = pend_q[look1_addr];
    assign pend_any = |pend_q;

endmodule

// File: rtl/yd_regfile_sb.sv
// Yduck two-write/two-read register file (ZE, DK, general registers, PC) with
// registered read addresses, write bypass and an integrated pending-write scoreboard.
module yd_regfile_sb
    import yd_pkg::*;
#(
    parameter int            DW     = 16,
    parameter int            AW     = 4,
    parameter logic [DW-1:0] PC_RST = '0
) (
    input logic         clk,
    input logic         rst,
    yd_regfile_sb_if.slave bus
);

    localparam int NGR = int'(num_gr(AW));
    localparam logic [AW-1:0] ZE_A = AW'(ZEA);
    localparam logic [AW-1:0] DK_A = AW'(DKA);
    localparam logic [AW-1:0] R0_A = AW'(R0A);
    localparam logic [AW-1:0] PC_A = AW'(pca(AW));

    logic [DW-1:0] gr_q [NGR];
    logic [DW-1:0] dk_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] pc_d;
    logic [AW-1:0] raddr0_r, raddr1_r;
    logic [AW-1:0] waddr0_r, waddr1_r;
    logic          we0_r, we1_r;
    logic [DW-1:0] din0_r, din1_r;

    function automatic logic is_gr(input logic [AW-1:0] a);
        return (a != ZE_A) && (a != DK_A) && (a != PC_A);
    endfunction

    function automatic logic [AW-1:0] gidx(input logic [AW-1:0] a);
        return a - R0_A;
    endfunction

    always_comb begin
        pc_d = pc_q + DW'(1);
        if (bus.jpc && bus.we0 && bus.waddr0 == PC_A)      pc_d = bus.din0;
        else if (bus.jpc && bus.we1 && bus.waddr1 == PC_A) pc_d = bus.din1;
        else if (bus.jpc || bus.hold)                      pc_d = pc_q;
    end

    // Port 1 is assigned first so a same-address port 0 write overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NGR; i++) gr_q[i] <= '0;
            dk_q     <= '0;
            pc_q     <= PC_RST;
            raddr0_r <= '0;
            raddr1_r <= '0;
            waddr0_r <= '0;
            waddr1_r <= '0;
            we0_r    <= 1'b0;
            we1_r    <= 1'b0;
            din0_r   <= '0;
            din1_r   <= '0;
        end else begin
            if (bus.we1 && is_gr(bus.waddr1)) gr_q[gidx(bus.waddr1)] <= bus.din1;
            if (bus.we0 && is_gr(bus.waddr0)) gr_q[gidx(bus.waddr0)] <= bus.din0;
            if (bus.we0 && bus.waddr0 == DK_A)      dk_q <= bus.din0;
            else if (bus.we1 && bus.waddr1 == DK_A) dk_q <= bus.din1;
            pc_q     <= pc_d;
            raddr0_r <= bus.raddr0;
            raddr1_r <= bus.raddr1;
            waddr0_r <= bus.waddr0;
            waddr1_r <= bus.waddr1;
            we0_r    <= bus.we0;
            we1_r    <= bus.we1;
            din0_r   <= bus.din0;
            din1_r   <= bus.din1;
        end
    end

    function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] a, input logic [DW-1:0] gr_val);
        if (a == ZE_A)                 return '0;
        if (a == PC_A)                 return pc_q;
        if (we0_r && waddr0_r == a)    return din0_r;
        if (we1_r && waddr1_r == a)    return din1_r;
        if (a == DK_A)                 return dk_q;
        return gr_val;
    endfunction

    assign bus.dout0 = rd_mux(raddr0_r, gr_q[gidx(raddr0_r)]);
    assign bus.dout1 = rd_mux(raddr1_r, gr_q[gidx(raddr1_r)]);
    assign bus.pc    = pc_q;

    assign bus.dkd = (bus.we0 && bus.waddr0 == DK_A) ? bus.din0 :
                     (bus.we1 && bus.waddr1 == DK_A) ? bus.din1 : dk_q;

    yd_scoreboard #(.AW(AW)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set        (bus.pset),
        .set_addr   (bus.psetaddr),
        .clr0       (bus.we0),
        .clr0_addr  (bus.waddr0),
        .clr1       (bus.we1),
        .clr1_addr  (bus.waddr1),
        .look0_addr (raddr0_r),
        .look1_addr (raddr1_r),
        .busy0      (bus.busy0),
        .busy1      (bus.busy1),
        .pend_any   (bus.pend_any)
    );

endmodule

// File: tb/tb_yd_regfile_sb.sv
// Directed bench for yd_regfile_sb: a 16-bit/AW=4 instance for most features and a
// 32-bit/AW=5 instance for wide PC wrap and top-of-map addressing.
module tb_yd_regfile_sb;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    yd_regfile_sb_if #(.DW(16), .AW(4)) a_if ();
    yd_regfile_sb_if #(.DW(32), .AW(5)) b_if ();

    yd_regfile_sb #(.DW(16), .AW(4), .PC_RST(16'h0000)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    yd_regfile_sb #(.DW(32), .AW(5), .PC_RST(32'h0000_0010)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.jpc = 1'b0; a_if.hold = 1'b0; a_if.we0 = 1'b0; a_if.we1 = 1'b0; a_if.pset = 1'b0;
    endtask

    task automatic idle_b();
        b_if.jpc = 1'b0; b_if.hold = 1'b0; b_if.we0 = 1'b0; b_if.we1 = 1'b0; b_if.pset = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        idle_a(); idle_b();
        a_if.din0 = '0; a_if.din1 = '0; a_if.waddr0 = '0; a_if.waddr1 = '0;
        a_if.raddr0 = '0; a_if.raddr1 = '0; a_if.psetaddr = '0;
        b_if.din0 = '0; b_if.din1 = '0; b_if.waddr0 = '0; b_if.waddr1 = '0;
        b_if.raddr0 = '0; b_if.raddr1 = '0; b_if.psetaddr = '0;
        tick(); tick();
        checks++; if (a_if.pc !== 16'h0000) $display("[TB] FAIL rst_pc actual=%h expected=0000", a_if.pc); else passed++;
        checks++; if (a_if.dout0 !== 16'h0000) $display("[TB] FAIL rst_dout0 actual=%h expected=0000", a_if.dout0); else passed++;
        checks++; if (a_if.dout1 !== 16'h0000) $display("[TB] FAIL rst_dout1 actual=%h expected=0000", a_if.dout1); else passed++;
        checks++; if ({a_if.busy0, a_if.busy1, a_if.pend_any} !== 3'b000) $display("[TB] FAIL rst_busy actual=%b expected=000", {a_if.busy0, a_if.busy1, a_if.pend_any}); else passed++;
        checks++; if (a_if.dkd !== 16'h0000) $display("[TB] FAIL rst_dkd actual=%h expected=0000", a_if.dkd); else passed++;
        checks++; if (b_if.pc !== 32'h0000_0010) $display("[TB] FAIL rst_pc_b actual=%h expected=00000010", b_if.pc); else passed++;
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (a_if.pc !== 16'(i)) $display("[TB] FAIL idle_pc%0d actual=%h expected=%h", i, a_if.pc, 16'(i)); else passed++;
        end
        checks++; if (a_if.dout0 !== 16'h0000) $display("[TB] FAIL read_ze actual=%h expected=0000", a_if.dout0); else passed++;
        checks++; if (a_if.pend_any !== 1'b0) $display("[TB] FAIL idle_pend_any actual=%b expected=0", a_if.pend_any); else passed++;
    endtask

    task automatic test_write_bypass();
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd2; a_if.din0 = 16'h1234; a_if.raddr0 = 4'd2;
        tick();
        checks++; if (a_if.dout0 !== 16'h1234) $display("[TB] FAIL bypass_r0 actual=%h expected=1234", a_if.dout0); else passed++;
        a_if.waddr0 = 4'd5; a_if.din0 = 16'hAAAA;
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd5; a_if.din1 = 16'h5555; a_if.raddr1 = 4'd5;
        tick();
        checks++; if (a_if.dout1 !== 16'hAAAA) $display("[TB] FAIL dual_wr_bypass actual=%h expected=AAAA", a_if.dout1); else passed++;
        idle_a();
        tick();
        checks++; if (a_if.dout1 !== 16'hAAAA) $display("[TB] FAIL dual_wr_state actual=%h expected=AAAA", a_if.dout1); else passed++;
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd3; a_if.din1 = 16'h0F0F; a_if.raddr0 = 4'd3;
        tick();
        checks++; if (a_if.dout0 !== 16'h0F0F) $display("[TB] FAIL port1_wr actual=%h expected=0F0F", a_if.dout0); else passed++;
        idle_a();
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd0; a_if.din0 = 16'hFFFF; a_if.raddr0 = 4'd0; a_if.raddr1 = 4'd2;
        tick();
        checks++; if (a_if.dout0 !== 16'h0000) $display("[TB] FAIL ze_wr actual=%h expected=0000", a_if.dout0); else passed++;
        checks++; if (a_if.dout1 !== 16'h1234) $display("[TB] FAIL r0_hold actual=%h expected=1234", a_if.dout1); else passed++;
        idle_a();
        tick();
        checks++; if (a_if.dout0 !== 16'h0000) $display("[TB] FAIL ze_state actual=%h expected=0000", a_if.dout0); else passed++;
    endtask

    task automatic test_pc();
        a_if.raddr0 = 4'd15;
        a_if.jpc = 1'b1; a_if.we0 = 1'b1; a_if.waddr0 = 4'd15; a_if.din0 = 16'h0100;
        tick();
        checks++; if (a_if.pc !== 16'h0100) $display("[TB] FAIL pc_load actual=%h expected=0100", a_if.pc); else passed++;
        checks++; if (a_if.dout0 !== 16'h0100) $display("[TB] FAIL pc_read actual=%h expected=0100", a_if.dout0); else passed++;
        idle_a();
        tick();
        checks++; if (a_if.pc !== 16'h0101) $display("[TB] FAIL pc_inc actual=%h expected=0101", a_if.pc); else passed++;
        checks++; if (a_if.dout0 !== 16'h0101) $display("[TB] FAIL pc_read_inc actual=%h expected=0101", a_if.dout0); else passed++;
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd15; a_if.din0 = 16'h7777;
        tick();
        checks++; if (a_if.pc !== 16'h0102) $display("[TB] FAIL pc_wr_nojpc actual=%h expected=0102", a_if.pc); else passed++;
        idle_a();
        a_if.hold = 1'b1;
        tick(); tick();
        checks++; if (a_if.pc !== 16'h0102) $display("[TB] FAIL pc_hold actual=%h expected=0102", a_if.pc); else passed++;
        a_if.hold = 1'b0;
        tick();
        checks++; if (a_if.pc !== 16'h0103) $display("[TB] FAIL pc_unhold actual=%h expected=0103", a_if.pc); else passed++;
        a_if.jpc = 1'b1;
        tick();
        checks++; if (a_if.pc !== 16'h0103) $display("[TB] FAIL pc_jpc_bubble actual=%h expected=0103", a_if.pc); else passed++;
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd15; a_if.din1 = 16'h2000;
        tick();
        checks++; if (a_if.pc !== 16'h2000) $display("[TB] FAIL pc_load_p1 actual=%h expected=2000", a_if.pc); else passed++;
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd15; a_if.din0 = 16'h3000; a_if.din1 = 16'h4000;
        tick();
        checks++; if (a_if.pc !== 16'h3000) $display("[TB] FAIL pc_load_prio actual=%h expected=3000", a_if.pc); else passed++;
        idle_a();
        tick();
        checks++; if (a_if.pc !== 16'h3001) $display("[TB] FAIL pc_inc2 actual=%h expected=3001", a_if.pc); else passed++;
    endtask

    task automatic test_dkd();
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd1; a_if.din1 = 16'hBEEF;
        #1;
        checks++; if (a_if.dkd !== 16'hBEEF) $display("[TB] FAIL dkd_p1 actual=%h expected=BEEF", a_if.dkd); else passed++;
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd1; a_if.din0 = 16'h1111; a_if.raddr1 = 4'd1;
        #1;
        checks++; if (a_if.dkd !== 16'h1111) $display("[TB] FAIL dkd_prio actual=%h expected=1111", a_if.dkd); else passed++;
        tick();
        idle_a();
        #1;
        checks++; if (a_if.dkd !== 16'h1111) $display("[TB] FAIL dkd_state actual=%h expected=1111", a_if.dkd); else passed++;
        checks++; if (a_if.dout1 !== 16'h1111) $display("[TB] FAIL dk_read actual=%h expected=1111", a_if.dout1); else passed++;
    endtask

    task automatic test_scoreboard();
        a_if.raddr0 = 4'd7; a_if.raddr1 = 4'd7;
        a_if.pset = 1'b1; a_if.psetaddr = 4'd7;
        tick();
        checks++; if ({a_if.busy0, a_if.busy1, a_if.pend_any} !== 3'b111) $display("[TB] FAIL pset_busy actual=%b expected=111", {a_if.busy0, a_if.busy1, a_if.pend_any}); else passed++;
        a_if.pset = 1'b0;
        tick();
        checks++; if (a_if.busy0 !== 1'b1) $display("[TB] FAIL pend_keep actual=%b expected=1", a_if.busy0); else passed++;
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd7; a_if.din0 = 16'h0055;
        tick();
        checks++; if ({a_if.busy0, a_if.pend_any} !== 2'b00) $display("[TB] FAIL wr_clear actual=%b expected=00", {a_if.busy0, a_if.pend_any}); else passed++;
        idle_a();
        a_if.pset = 1'b1; a_if.psetaddr = 4'd7;
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd7; a_if.din1 = 16'h0066;
        tick();
        checks++; if (a_if.busy0 !== 1'b1) $display("[TB] FAIL set_beats_clr actual=%b expected=1", a_if.busy0); else passed++;
        checks++; if (a_if.dout0 !== 16'h0066) $display("[TB] FAIL r5_data actual=%h expected=0066", a_if.dout0); else passed++;
        idle_a();
        a_if.we1 = 1'b1; a_if.waddr1 = 4'd7;
        tick();
        checks++; if ({a_if.busy1, a_if.pend_any} !== 2'b00) $display("[TB] FAIL p1_clear actual=%b expected=00", {a_if.busy1, a_if.pend_any}); else passed++;
        idle_a();
        a_if.pset = 1'b1; a_if.psetaddr = 4'd0; a_if.raddr0 = 4'd0;
        tick();
        checks++; if ({a_if.busy0, a_if.pend_any} !== 2'b00) $display("[TB] FAIL pset_ze actual=%b expected=00", {a_if.busy0, a_if.pend_any}); else passed++;
        a_if.psetaddr = 4'd15; a_if.raddr0 = 4'd15;
        tick();
        checks++; if ({a_if.busy0, a_if.pend_any} !== 2'b00) $display("[TB] FAIL pset_pc actual=%b expected=00", {a_if.busy0, a_if.pend_any}); else passed++;
        a_if.pset = 1'b0;
    endtask

    task automatic test_reset_midop();
        a_if.pset = 1'b1; a_if.psetaddr = 4'd7;
        tick();
        checks++; if (a_if.pend_any !== 1'b1) $display("[TB] FAIL pre_rst_pend actual=%b expected=1", a_if.pend_any); else passed++;
        rst_a = 1'b1;
        a_if.psetaddr = 4'd4;
        a_if.we0 = 1'b1; a_if.waddr0 = 4'd2; a_if.din0 = 16'h9999; a_if.raddr0 = 4'd2;
        tick();
        checks++; if ({a_if.pend_any, a_if.busy0} !== 2'b00) $display("[TB] FAIL rst_midop_pend actual=%b expected=00", {a_if.pend_any, a_if.busy0}); else passed++;
        checks++; if (a_if.pc !== 16'h0000) $display("[TB] FAIL rst_midop_pc actual=%h expected=0000", a_if.pc); else passed++;
        rst_a = 1'b0;
        idle_a();
        tick();
        checks++; if (a_if.dout0 !== 16'h0000) $display("[TB] FAIL rst_midop_r0 actual=%h expected=0000", a_if.dout0); else passed++;
        checks++; if (a_if.pc !== 16'h0001) $display("[TB] FAIL rst_midop_pc1 actual=%h expected=0001", a_if.pc); else passed++;
    endtask

    task automatic test_wide();
        rst_b = 1'b0;
        b_if.raddr1 = 5'd31;
        b_if.jpc = 1'b1; b_if.we0 = 1'b1; b_if.waddr0 = 5'd31; b_if.din0 = 32'hFFFF_FFFF;
        tick();
        checks++; if (b_if.pc !== 32'hFFFF_FFFF) $display("[TB] FAIL wide_load actual=%h expected=FFFFFFFF", b_if.pc); else passed++;
        checks++; if (b_if.dout1 !== 32'hFFFF_FFFF) $display("[TB] FAIL wide_pc_read actual=%h expected=FFFFFFFF", b_if.dout1); else passed++;
        idle_b();
        tick();
        checks++; if (b_if.pc !== 32'h0000_0000) $display("[TB] FAIL wide_wrap actual=%h expected=00000000", b_if.pc); else passed++;
        b_if.we0 = 1'b1; b_if.waddr0 = 5'd30; b_if.din0 = 32'hCAFE_F00D; b_if.raddr0 = 5'd30;
        tick();
        checks++; if (b_if.dout0 !== 32'hCAFE_F00D) $display("[TB] FAIL wide_r30 actual=%h expected=CAFEF00D", b_if.dout0); else passed++;
        checks++; if (b_if.dout1 !== 32'h0000_0001) $display("[TB] FAIL wide_pc_read1 actual=%h expected=00000001", b_if.dout1); else passed++;
        idle_b();
        tick();
        checks++; if (b_if.dout0 !== 32'hCAFE_F00D) $display("[TB] FAIL wide_r30_state actual=%h expected=CAFEF00D", b_if.dout0); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_pc();
        test_dkd();
        test_scoreboard();
        test_reset_midop();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
